cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 117 +++++++++++
 tb/tb_cpu_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer.
// Each instruction walks FETCH -> DECODE -> EXEC -> WB (4 cycles); an all-zero
// instruction word seen in DECODE parks the FSM in HALT until clear_halt.
// Optional feature macro: SEQ_BREAKPOINT_EN adds bp_en/bp_addr/bp_hit, which
// stop a free run in IDLE when the next fetch address matches bp_addr.
module cpu_sequencer #(
    parameter int PC_W  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_mode,
    input  logic             step,
    input  logic             clear_halt,
    input  logic [31:0]      instruction,
    input  logic             dec_reg_write,
`ifdef SEQ_BREAKPOINT_EN
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             bp_hit,
`endif
    output logic [PC_W-1:0]  pc,
    output logic             ir_load,
    output logic             rf_we,
    output logic             result_en,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_inc;
    logic            bp_stop;

    assign pc_inc = pc + PC_W'(1);

`ifdef SEQ_BREAKPOINT_EN
    assign bp_stop = bp_en && (pc_inc == bp_addr);
`else
    assign bp_stop = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (step) state_next = FETCH;
            FETCH:   state_next = DECODE;
            DECODE:  state_next = (instruction == 32'h0) ? HALT : EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = (run_mode && !bp_stop) ? FETCH : IDLE;
            HALT:    if (clear_halt) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes and status, decoded from the registered state only
    always_comb begin
        ir_load   = 1'b0;
        rf_we     = 1'b0;
        result_en = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        unique case (state)
            FETCH:   begin ir_load = 1'b1; busy = 1'b1; end
            DECODE:  busy = 1'b1;
            EXEC:    busy = 1'b1;
            WB:      begin rf_we = dec_reg_write; result_en = 1'b1; busy = 1'b1; end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // Program counter and saturating retire counter advance on write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            retired <= '0;
        end else if (state == WB) begin
            pc <= pc_inc;
            if (retired != '1) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

`ifdef SEQ_BREAKPOINT_EN
    // One-cycle breakpoint pulse, only when a free run would have refetched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_hit <= 1'b0;
        end else begin
            bp_hit <= (state == WB) && run_mode && bp_stop;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (PC_W=3, CNT_W=8).
// Optional feature macro: SEQ_BREAKPOINT_EN enables the breakpoint scenario.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_mode;
    logic        step;
    logic        clear_halt;
    logic [31:0] instruction;
    logic        dec_reg_write;
    logic [2:0]  pc;
    logic        ir_load;
    logic        rf_we;
    logic        result_en;
    logic        busy;
    logic        halted;
    logic [7:0]  retired;
`ifdef SEQ_BREAKPOINT_EN
    logic        bp_en;
    logic [2:0]  bp_addr;
    logic        bp_hit;
`endif

    logic [31:0] rom [0:7];

    int n_tests = 0;
    int n_fail  = 0;

    assign instruction   = rom[pc];
    assign dec_reg_write = instruction[0];

    cpu_sequencer #(.PC_W(3), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .run_mode      (run_mode),
        .step          (step),
        .clear_halt    (clear_halt),
        .instruction   (instruction),
        .dec_reg_write (dec_reg_write),
`ifdef SEQ_BREAKPOINT_EN
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
        .bp_hit        (bp_hit),
`endif
        .pc            (pc),
        .ir_load       (ir_load),
        .rf_we         (rf_we),
        .result_en     (result_en),
        .busy          (busy),
        .halted        (halted),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic rom_fill(input logic [31:0] word);
        for (int i = 0; i < 8; i++) rom[i] = word;
    endtask

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n_res, n_fetch, last, gaps_bad, first_f, second_f, extra, found, seen_pulse;
        int pcs [0:8];
        int seq_bad;

        reset      = 1'b1;
        run_mode   = 1'b0;
        step       = 1'b0;
        clear_halt = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
        bp_en      = 1'b0;
        bp_addr    = '0;
`endif
        rom_fill(32'h11);
        rom[1] = 32'h10;

        // Reset state, checked before any clock edge
        #2;
        check("rst_pc", pc, 0);
        check("rst_retired", retired, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_strobes", {ir_load, rf_we, result_en}, 0);
        do_reset();

        // Single step: ir_load cycle 1, result_en cycle 4, then IDLE with pc=1
        run_mode = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        check("ss_ir_load_c1", ir_load, 1);
        check("ss_busy_c1", busy, 1);
        tick();
        check("ss_ir_load_c2", ir_load, 0);
        tick();
        check("ss_exec_strobes", {ir_load, rf_we, result_en}, 0);
        tick();
        check("ss_result_en_c4", result_en, 1);
        check("ss_rf_we_c4", rf_we, 1);
        check("ss_pc_in_wb", pc, 0);
        tick();
        check("ss_idle_busy", busy, 0);
        check("ss_pc_after", pc, 1);
        check("ss_retired", retired, 1);
        check("ss_result_en_c5", result_en, 0);
        // Second step: decoder says no register write
        step = 1'b1; tick(); step = 1'b0;
        tick(); tick(); tick();
        check("ss2_result_en", result_en, 1);
        check("ss2_rf_we", rf_we, 0);
        tick();
        check("ss2_pc", pc, 2);
        check("ss2_retired", retired, 2);

        // Free run into a zero word: 6 retirements 4 cycles apart, then HALT
        for (int i = 0; i < 6; i++) rom[i] = 32'h101 + i;
        rom[6] = 32'h0;
        rom[7] = 32'h0;
        do_reset();
        run_mode = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        n_res = 0; last = 0; gaps_bad = 0;
        for (int c = 1; c <= 80 && !halted; c++) begin
            if (result_en) begin
                n_res++;
                if (last != 0 && (c - last) != 4) gaps_bad++;
                last = c;
            end
            tick();
        end
        check("fr_pulses", n_res, 6);
        check("fr_gaps", gaps_bad, 0);
        check("fr_halted", halted, 1);
        check("fr_pc", pc, 6);
        check("fr_retired", retired, 6);
        check("fr_busy", busy, 0);
        step = 1'b1; tick(); tick(); step = 1'b0;
        check("halt_step_ignored", halted, 1);
        check("halt_step_busy", busy, 0);
        clear_halt = 1'b1; tick(); clear_halt = 1'b0;
        check("clr_halted", halted, 0);
        check("clr_busy", busy, 0);
        check("clr_pc", pc, 6);

        // Step held for 10 cycles in step mode: fetches at cycles 1 and 6
        rom_fill(32'h11);
        do_reset();
        run_mode = 1'b0;
        step = 1'b1;
        n_fetch = 0; first_f = 0; second_f = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (ir_load) begin
                n_fetch++;
                if (n_fetch == 1) first_f = c;
                if (n_fetch == 2) second_f = c;
            end
        end
        step = 1'b0;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ir_load) extra++;
        end
        check("busy_fetches", n_fetch, 2);
        check("busy_first", first_f, 1);
        check("busy_second", second_f, 6);
        check("busy_no_queue", extra, 0);
        check("busy_retired", retired, 2);

        // Reset during EXEC of pc=2
        do_reset();
        run_mode = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (ir_load && pc == 3'd2) found = 1;
            else tick();
        end
        check("rmo_reach_pc2", found, 1);
        tick(); tick();
        check("rmo_in_exec", {busy, result_en, rf_we}, 3'b100);
        check("rmo_retired_before", retired, 2);
        #2 reset = 1'b1;
        #1;
        check("rmo_async_busy", busy, 0);
        check("rmo_async_pc", pc, 0);
        check("rmo_async_retired", retired, 0);
        check("rmo_async_strobes", {ir_load, rf_we, result_en, halted}, 0);
        seen_pulse = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (rf_we || result_en) seen_pulse++;
        end
        reset = 1'b0;
        tick();
        if (rf_we || result_en) seen_pulse++;
        check("rmo_no_wb_pulse", seen_pulse, 0);
        check("rmo_pc_after", pc, 0);

        // Wrap: 9 instructions, fetch pcs 0..7,0 then pc=1
        rom_fill(32'h11);
        do_reset();
        run_mode = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        n_res = 0; n_fetch = 0;
        for (int c = 0; c < 80 && n_res < 9; c++) begin
            if (ir_load && n_fetch < 9) begin
                pcs[n_fetch] = int'(pc);
                n_fetch++;
            end
            if (result_en) begin
                n_res++;
                if (n_res == 9) run_mode = 1'b0;
            end
            tick();
        end
        tick(); tick();
        seq_bad = 0;
        for (int i = 0; i < 9; i++) if (pcs[i] != (i % 8)) seq_bad++;
        check("wrap_fetches", n_fetch, 9);
        check("wrap_pc_seq", seq_bad, 0);
        check("wrap_pc9_is_0", pcs[8], 0);
        check("wrap_pc_final", pc, 1);
        check("wrap_retired", retired, 9);
        check("wrap_idle", busy, 0);

        // Retire counter saturates at 255 after 257 instructions
        do_reset();
        run_mode = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        n_res = 0;
        for (int c = 0; c < 1300 && n_res < 257; c++) begin
            if (result_en) begin
                n_res++;
                if (n_res == 257) run_mode = 1'b0;
            end
            tick();
        end
        tick(); tick();
        check("sat_pulses", n_res, 257);
        check("sat_retired", retired, 255);
        check("sat_pc", pc, 1);

`ifdef SEQ_BREAKPOINT_EN
        // Breakpoint at 3: stops in IDLE with one bp_hit, step resumes there
        do_reset();
        bp_en = 1'b1;
        bp_addr = 3'd3;
        run_mode = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        n_res = 0; extra = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_en) n_res++;
            if (bp_hit) extra++;
            tick();
        end
        check("bp_hits", extra, 1);
        check("bp_retired_cnt", n_res, 3);
        check("bp_pc", pc, 3);
        check("bp_idle", busy, 0);
        step = 1'b1; tick(); step = 1'b0;
        check("bp_resume_fetch", ir_load, 1);
        check("bp_resume_pc", pc, 3);
        n_res = 0; extra = 0;
        for (int c = 1; c <= 20; c++) begin
            if (result_en) n_res++;
            if (bp_hit) extra++;
            tick();
        end
        check("bp_continue_pulses", n_res, 5);
        check("bp_continue_hits", extra, 0);
        check("bp_continue_retired", retired, 8);
        bp_en = 1'b0;
        run_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
